// File: rtl/dac_stream_pkg.sv
// Shared types and helpers for the DAC AXIS streaming block.
package dac_stream_pkg;

  localparam int CNTW = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] value,
                                              input logic            event_hit);
    return (event_hit && (value != '1)) ? value + CNTW'(1) : value;
  endfunction

endpackage

// File: rtl/dacfifo.sv
// Sample FIFO between the DSP side and the DAC AXIS master.
module dacfifo #(
  parameter int DW    = 256,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: the storage array has no reset; only pointers and level define
  // which entries are valid, so resetting the words would just cost flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/axis_dac_stream.sv
// Primed AXIS master feeding one RFDC DAC channel from the DSP sample stream.
module axis_dac_stream
  import dac_stream_pkg::*;
#(
  parameter int DW    = 256,
  parameter int DEPTH = 8,
  parameter int PRIME = DEPTH / 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DW-1:0]          din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [DW-1:0]          m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   streaming,
  output logic [CNTW-1:0]        underflow_cnt,
  output logic [CNTW-1:0]        overflow_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;

  state_t        state;
  state_t        state_nxt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;
  logic          push;
  logic          load;
  logic          underflow_evt;
  logic          primed;

  assign push      = din_valid && !fifo_full;
  assign din_ready = !fifo_full;
  assign primed    = (level >= LW'(PRIME));

  dacfifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (!enable),
    .push  (push),
    .pop   (load),
    .din   (din),
    .head  (fifo_head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  state_nxt = ST_PRIME;
        ST_PRIME: if (primed) state_nxt = ST_RUN;
        ST_RUN:   state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // The PRIME->RUN edge preloads the head so valid data is present from the first RUN cycle.
  always_comb begin
    load          = 1'b0;
    underflow_evt = 1'b0;
    m_tvalid      = (state == ST_RUN);
    streaming     = (state == ST_RUN);
    if (enable) begin
      unique case (state)
        ST_PRIME: load = primed;
        ST_RUN: begin
          if (m_tready) begin
            load          = !fifo_empty;
            underflow_evt = fifo_empty;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        m_tdata <= '0;
    else if (!enable) m_tdata <= '0;
    else if (load)    m_tdata <= fifo_head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_cnt <= '0;
      overflow_cnt  <= '0;
    end else begin
      underflow_cnt <= sat_inc(underflow_cnt, underflow_evt);
      overflow_cnt  <= sat_inc(overflow_cnt, din_valid && fifo_full);
    end
  end

endmodule
